// File: rtl/dest_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dest_demux_pkg
// Purpose  : Shared definitions for the destination demultiplexer: default
//            widths, state encoding and destination-field-to-port mapping.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dest_demux_pkg;

    // Default widths for the word and the per-destination push counters.
    localparam int c_data_w_default = 10;
    localparam int c_cnt_w_default  = 8;

    // Number of destination ports (P4..P7).
    localparam int c_num_dest = 4;

    // State encoding, 2-bit registered.
    localparam logic [1:0] c_st_idle   = 2'b00;
    localparam logic [1:0] c_st_active = 2'b01;
    localparam logic [1:0] c_st_drain  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = c_st_idle,
        ST_ACTIVE = c_st_active,
        ST_DRAIN  = c_st_drain
    } state_t;

    // Destination field value for each output port.
    localparam logic [1:0] c_dest_p4 = 2'b00;
    localparam logic [1:0] c_dest_p5 = 2'b01;
    localparam logic [1:0] c_dest_p6 = 2'b10;
    localparam logic [1:0] c_dest_p7 = 2'b11;

    // One-hot port select, bit 0 = P4 ... bit 3 = P7.
    function automatic logic [c_num_dest-1:0] dest_onehot(input logic [1:0] dest);
        logic [c_num_dest-1:0] sel;
        sel = '0;
        case (dest)
            c_dest_p4: sel = 4'b0001;
            c_dest_p5: sel = 4'b0010;
            c_dest_p6: sel = 4'b0100;
            c_dest_p7: sel = 4'b1000;
            default:   sel = '0;
        endcase
        return sel;
    endfunction

endpackage : dest_demux_pkg
`default_nettype wire

// File: rtl/dest_demux_skid_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : skid_fifo2
// Purpose  : Two-entry FIFO used as the skid buffer between the source FIFO
//            read port and the destination write strobes.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            push, push_data   - write strobe and write data
//            pop               - remove head (ignored when empty)
//            head              - current head word
//            occupancy, empty  - fill level (0..2) and empty flag
// Revision : 1.0 - initial release
// ============================================================================
module skid_fifo2 #(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        occupancy,
    output logic              empty
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_pop;

    assign w_pop = pop && (r_count != 2'd0);

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head      = r_mem[r_rd_ptr];
    assign occupancy = r_count;
    assign empty     = (r_count == 2'd0);

endmodule : skid_fifo2
`default_nettype wire

// File: rtl/dest_demux.sv
`default_nettype none
// ============================================================================
// Module   : dest_demux
// Purpose  : Pops words from a source FIFO and writes each one, unmodified,
//            to one of four destination FIFOs (P4..P7) selected by the two
//            MSBs of the word. In-order, head-of-line blocking on almost-full.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            enable                     - accept new words / drain when low
//            empty_in, data_in, pop_in  - source FIFO read interface
//            almost_full_P4..P7         - destination back-pressure
//            push_P4..P7, data_out      - destination write interface
//            cnt_P4..P7                 - per-destination push counters
//            busy                       - word buffered or read in flight
// Revision : 1.0 - initial release
// ============================================================================
module dest_demux
    import dest_demux_pkg::*;
#(
    parameter int DATA_W = c_data_w_default,
    parameter int CNT_W  = c_cnt_w_default
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              empty_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              pop_in,
    input  logic              almost_full_P4,
    input  logic              almost_full_P5,
    input  logic              almost_full_P6,
    input  logic              almost_full_P7,
    output logic              push_P4,
    output logic              push_P5,
    output logic              push_P6,
    output logic              push_P7,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  cnt_P4,
    output logic [CNT_W-1:0]  cnt_P5,
    output logic [CNT_W-1:0]  cnt_P6,
    output logic [CNT_W-1:0]  cnt_P7,
    output logic              busy
);

    state_t                  r_state;
    logic                    r_in_flight;
    logic [CNT_W-1:0]        r_cnt [c_num_dest];

    logic [DATA_W-1:0]       w_head;
    logic [1:0]              w_occ;
    logic                    w_empty;
    logic [1:0]              w_head_dest;
    logic [c_num_dest-1:0]   w_af_vec;
    logic                    w_head_af;
    logic                    w_push_now;
    logic [c_num_dest-1:0]   w_push_vec;
    logic [2:0]              w_slots_used;
    logic                    w_pop_now;

    skid_fifo2 #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (r_in_flight),
        .push_data (data_in),
        .pop       (w_push_now),
        .head      (w_head),
        .occupancy (w_occ),
        .empty     (w_empty)
    );

    // Push decode: only the head may leave, so a blocked head stalls all ports.
    assign w_af_vec    = {almost_full_P7, almost_full_P6, almost_full_P5, almost_full_P4};
    assign w_head_dest = w_head[DATA_W-1 -: 2];
    assign w_head_af   = w_af_vec[w_head_dest];
    assign w_push_now  = !reset && !w_empty && !w_head_af;
    assign w_push_vec  = w_push_now ? dest_onehot(w_head_dest) : '0;

    // Slots committed at the next edge: stored words plus the word arriving
    // from an earlier pop, minus the head leaving now. A new pop is issued
    // only if a slot is guaranteed for its data one cycle later.
    assign w_slots_used = {1'b0, w_occ} + {2'b00, r_in_flight} - {2'b00, w_push_now};
    assign w_pop_now    = !reset && (r_state == ST_ACTIVE) && !empty_in && (w_slots_used < 3'd2);

    assign pop_in   = w_pop_now;
    assign push_P4  = w_push_vec[0];
    assign push_P5  = w_push_vec[1];
    assign push_P6  = w_push_vec[2];
    assign push_P7  = w_push_vec[3];
    assign data_out = (!reset && !w_empty) ? w_head : '0;
    assign busy     = !reset && ((w_occ != 2'd0) || r_in_flight);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_in_flight <= 1'b0;
        end else begin
            r_in_flight <= w_pop_now;
            case (r_state)
                ST_IDLE: begin
                    if (enable) r_state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (!enable) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (enable) begin
                        r_state <= ST_ACTIVE;
                    end else if (w_empty && !r_in_flight) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar i = 0; i < c_num_dest; i++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt[i] <= '0;
                end else if (w_push_vec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign cnt_P4 = r_cnt[0];
    assign cnt_P5 = r_cnt[1];
    assign cnt_P6 = r_cnt[2];
    assign cnt_P7 = r_cnt[3];

endmodule : dest_demux
`default_nettype wire

// File: tb/tb_dest_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_dest_demux
// Purpose  : Directed self-checking bench for dest_demux. A behavioural
//            source FIFO feeds the DUT; every pushed word is compared in
//            order against the list of words handed to the source.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_dest_demux;
    import dest_demux_pkg::*;

    localparam int c_dw = 10;
    localparam int c_cw = 8;

    logic            clk;
    logic            reset;
    logic            enable;
    logic            empty_in;
    logic [c_dw-1:0] data_in;
    logic            pop_in;
    logic            almost_full_P4, almost_full_P5, almost_full_P6, almost_full_P7;
    logic            push_P4, push_P5, push_P6, push_P7;
    logic [c_dw-1:0] data_out;
    logic [c_cw-1:0] cnt_P4, cnt_P5, cnt_P6, cnt_P7;
    logic            busy;

    dest_demux #(.DATA_W(c_dw), .CNT_W(c_cw)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .empty_in       (empty_in),
        .data_in        (data_in),
        .pop_in         (pop_in),
        .almost_full_P4 (almost_full_P4),
        .almost_full_P5 (almost_full_P5),
        .almost_full_P6 (almost_full_P6),
        .almost_full_P7 (almost_full_P7),
        .push_P4        (push_P4),
        .push_P5        (push_P5),
        .push_P6        (push_P6),
        .push_P7        (push_P7),
        .data_out       (data_out),
        .cnt_P4         (cnt_P4),
        .cnt_P5         (cnt_P5),
        .cnt_P6         (cnt_P6),
        .cnt_P7         (cnt_P7),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              checks   = 0;
    int              errors   = 0;
    int              n_pushes = 0;
    logic [c_dw-1:0] src_q [$];
    logic [c_dw-1:0] exp_q [$];
    logic [c_cw-1:0] exp_cnt [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pv();
        return {push_P7, push_P6, push_P5, push_P4};
    endfunction

    task automatic src_add(input logic [c_dw-1:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
        empty_in = 1'b0;
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_cnt_P4"}, 32'(cnt_P4), 32'(exp_cnt[0]));
        chk({tag, "_cnt_P5"}, 32'(cnt_P5), 32'(exp_cnt[1]));
        chk({tag, "_cnt_P6"}, 32'(cnt_P6), 32'(exp_cnt[2]));
        chk({tag, "_cnt_P7"}, 32'(cnt_P7), 32'(exp_cnt[3]));
    endtask

    // One clock cycle: score this cycle's pushes, step the edge, then model
    // the source FIFO (data valid the cycle after a pop). Returns at negedge+1.
    task automatic tick();
        logic            s_pop;
        logic [3:0]      s_push;
        logic [c_dw-1:0] s_dout;
        logic [c_dw-1:0] e;
        #1;
        s_pop  = pop_in;
        s_push = pv();
        s_dout = data_out;
        if (s_push != 4'b0000) begin
            n_pushes++;
            chk("push_onehot", 32'($countones(s_push)), 32'd1);
            if (exp_q.size() == 0) begin
                chk("push_unexpected", 32'(s_push), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("push_data", 32'(s_dout), 32'(e));
                chk("push_port", 32'(s_push), 32'(4'b0001 << e[c_dw-1 -: 2]));
                exp_cnt[e[c_dw-1 -: 2]] = exp_cnt[e[c_dw-1 -: 2]] + 8'd1;
            end
        end
        @(posedge clk);
        #1;
        if (s_pop) begin
            if (src_q.size() > 0) data_in = src_q.pop_front();
            else chk("pop_while_empty", 32'(s_pop), 32'd0);
        end
        empty_in = (src_q.size() == 0);
        @(negedge clk);
        #1;
    endtask

    initial begin : main
        logic [3:0] t2_push [7];
        logic       t2_pop  [7];
        int         pops;
        int         base;
        int         guard;

        t2_push = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        t2_pop  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) exp_cnt[i] = 8'd0;

        reset = 1'b1; enable = 1'b0; empty_in = 1'b1; data_in = '0;
        almost_full_P4 = 1'b0; almost_full_P5 = 1'b0;
        almost_full_P6 = 1'b0; almost_full_P7 = 1'b0;

        // Reset held two cycles; outputs forced low throughout.
        @(negedge clk); #1;
        chk("rst_pop", 32'(pop_in), 32'd0);
        chk("rst_push", 32'(pv()), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        chk("rst2_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Enabled with empty source: nothing happens.
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("idle_pop", 32'(pop_in), 32'd0);
            chk("idle_push", 32'(pv()), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            tick();
        end
        chk_cnts("idle");

        // One word per destination, first push two cycles after first pop.
        src_add(10'b0010000011);
        src_add(10'b0110000001);
        src_add(10'b1010000010);
        src_add(10'b1110000100);
        #1;
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("route_pop_c%0d", k), 32'(pop_in), 32'(t2_pop[k]));
            chk($sformatf("route_push_c%0d", k), 32'(pv()), 32'(t2_push[k]));
            tick();
        end
        chk("route_busy", 32'(busy), 32'd0);
        chk("route_cnt_P4", 32'(cnt_P4), 32'd1);
        chk("route_cnt_P7", 32'(cnt_P7), 32'd1);
        chk_cnts("route");

        // Eight words to blocked P5: skid fills with two, then pops stop.
        almost_full_P5 = 1'b1;
        for (int k = 1; k <= 8; k++) src_add({2'b01, 8'(k)});
        #1;
        pops = 0;
        for (int k = 0; k < 8; k++) begin
            if (pop_in) pops++;
            chk("blk_push", 32'(pv()), 32'd0);
            tick();
        end
        chk("blk_pops", 32'(pops), 32'd2);
        chk("blk_pop_now", 32'(pop_in), 32'd0);
        chk("blk_busy", 32'(busy), 32'd1);
        almost_full_P5 = 1'b0;
        #1;
        guard = 0;
        while ((src_q.size() != 0 || busy) && guard < 40) begin
            tick();
            guard++;
        end
        chk("blk_drain_timeout", 32'(guard < 40), 32'd1);
        chk("blk_cnt_P5", 32'(cnt_P5), 32'd9);  // 1 earlier + 8 here
        chk_cnts("blk");

        // Head-of-line: blocked P6 head holds back a P4 word behind it.
        almost_full_P6 = 1'b1;
        src_add(10'b1010100101);
        src_add(10'b0001011010);
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("hol_push", 32'(pv()), 32'd0);
            tick();
        end
        almost_full_P6 = 1'b0;
        #1;
        chk("hol_first_push", 32'(pv()), 32'(4'b0100));
        chk("hol_first_dout", 32'(data_out), 32'(10'b1010100101));
        tick();
        chk("hol_second_push", 32'(pv()), 32'(4'b0001));
        chk("hol_second_dout", 32'(data_out), 32'(10'b0001011010));
        tick();
        chk("hol_busy", 32'(busy), 32'd0);
        chk("hol_dout_empty", 32'(data_out), 32'd0);

        // Drain: two words buffered, enable dropped, both still delivered.
        almost_full_P7 = 1'b1;
        src_add(10'b1100110011);
        src_add(10'b1111001100);
        #1;
        for (int k = 0; k < 4; k++) tick();
        chk("drain_busy_pre", 32'(busy), 32'd1);
        enable = 1'b0;
        #1;
        tick();
        almost_full_P7 = 1'b0;
        #1;
        base = n_pushes;
        for (int k = 0; k < 6; k++) begin
            chk("drain_pop", 32'(pop_in), 32'd0);
            tick();
        end
        chk("drain_pushes", 32'(n_pushes - base), 32'd2);
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_state", 32'(dut.r_state), 32'(c_st_idle));
        chk_cnts("drain");

        // Reset with a buffered word and a pop in flight discards both.
        enable = 1'b1;
        almost_full_P4 = 1'b1;
        src_add(10'b0000010001);
        src_add(10'b0000010010);
        src_add(10'b0000010011);
        #1;
        tick();
        tick();
        chk("mrst_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mrst_pop", 32'(pop_in), 32'd0);
        chk("mrst_push", 32'(pv()), 32'd0);
        chk("mrst_dout", 32'(data_out), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        tick();
        src_q.delete();
        exp_q.delete();
        empty_in = 1'b1;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 8'd0;
        reset = 1'b0;
        almost_full_P4 = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("mrst_post_push", 32'(pv()), 32'd0);
            tick();
        end
        chk("mrst_busy_post", 32'(busy), 32'd0);
        chk_cnts("mrst");

        // 256 pushes to P7: counter wraps back to zero.
        for (int k = 0; k < 256; k++) src_add({2'b11, 8'(k)});
        #1;
        base  = n_pushes;
        guard = 0;
        while ((n_pushes - base) < 256 && guard < 400) begin
            tick();
            guard++;
        end
        chk("wrap_pushes", 32'(n_pushes - base), 32'd256);
        guard = 0;
        while (busy && guard < 10) begin
            tick();
            guard++;
        end
        chk("wrap_cnt_P7", 32'(cnt_P7), 32'd0);
        chk("wrap_cnt_P4", 32'(cnt_P4), 32'd0);
        chk_cnts("wrap");
        chk("wrap_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dest_demux
`default_nettype wire
